// File: rtl/output_register.sv
`default_nettype none
// ============================================================================
//  Module      : output_register
//  Description : Shadow image of the physical output pins. Single bits are
//                written by address (load/set/clear/toggle) and read back by
//                address; an update strobe commits the whole image to the
//                registered output pins. An optional watchdog forces the
//                pins low when no update arrives for WDT_CYCLES clocks.
//  Optional    : OUTPUT_WATCHDOG_EN enables the watchdog counter/state.
//                When undefined, wdtTrip is tied low and wdtClear is ignored.
//  Ports       : clk, reset (async active-low)
//                outputWrite/outputWriteAddr/outputWriteData/outputOp : bit write
//                outputRead/outputReadAddr -> outputReadOut           : bit read-back
//                outputUpdate : commit shadow to outputs
//                wdtClear     : leave watchdog-tripped state
//                outputs, wdtTrip, addrErr (1-cycle out-of-range pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module output_register #(
  parameter int OUT_NUM      = 8,
  parameter int OUT_ADDR_LEN = 3,
  parameter int WDT_CYCLES   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    outputWrite,
  input  logic [OUT_ADDR_LEN-1:0] outputWriteAddr,
  input  logic                    outputWriteData,
  input  logic [1:0]              outputOp,
  input  logic                    outputRead,
  input  logic [OUT_ADDR_LEN-1:0] outputReadAddr,
  output logic                    outputReadOut,
  input  logic                    outputUpdate,
  input  logic                    wdtClear,
  output logic [OUT_NUM-1:0]      outputs,
  output logic                    wdtTrip,
  output logic                    addrErr
);

  localparam logic [1:0] c_OP_LOAD  = 2'b00;
  localparam logic [1:0] c_OP_SET   = 2'b01;
  localparam logic [1:0] c_OP_CLEAR = 2'b10;
  localparam logic [OUT_ADDR_LEN:0] c_OUT_NUM = (OUT_ADDR_LEN+1)'(OUT_NUM);

  logic [OUT_NUM-1:0] r_shadow;
  logic [OUT_NUM-1:0] w_shadowNext;
  logic [OUT_NUM-1:0] r_outputs;
  logic               r_readOut;
  logic               r_addrErr;
  logic               w_readBit;
  logic               w_writeInRange;
  logic               w_readInRange;

  // Widen by one bit so the compare also works when OUT_NUM == 2**OUT_ADDR_LEN.
  assign w_writeInRange = {1'b0, outputWriteAddr} < c_OUT_NUM;
  assign w_readInRange  = {1'b0, outputReadAddr}  < c_OUT_NUM;

  // Next shadow image including this edge's write; out-of-range addresses
  // match no bit and leave the image untouched. The read-back samples the
  // post-write image so a same-edge read sees the new value.
  always_comb begin
    w_shadowNext = r_shadow;
    w_readBit    = 1'b0;
    for (int i = 0; i < OUT_NUM; i++) begin
      if (outputWrite && (outputWriteAddr == OUT_ADDR_LEN'(i))) begin
        case (outputOp)
          c_OP_LOAD:  w_shadowNext[i] = outputWriteData;
          c_OP_SET:   w_shadowNext[i] = 1'b1;
          c_OP_CLEAR: w_shadowNext[i] = 1'b0;
          default:    w_shadowNext[i] = ~r_shadow[i];
        endcase
      end
    end
    for (int i = 0; i < OUT_NUM; i++) begin
      if (outputReadAddr == OUT_ADDR_LEN'(i)) begin
        w_readBit = w_shadowNext[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow  <= '0;
      r_readOut <= 1'b0;
      r_addrErr <= 1'b0;
    end else begin
      r_shadow  <= w_shadowNext;
      if (outputRead && w_readInRange) begin
        r_readOut <= w_readBit;
      end
      r_addrErr <= (outputWrite && !w_writeInRange) ||
                   (outputRead  && !w_readInRange);
    end
  end

`ifdef OUTPUT_WATCHDOG_EN
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    TRIPPED = 1'b1
  } wdtState_t;

  localparam int c_CNT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WDT_CYCLES - 1);

  wdtState_t          r_state;
  wdtState_t          w_stateNext;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_countNext;
  logic [OUT_NUM-1:0] w_outputsNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_count   <= '0;
      r_outputs <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_outputs <= w_outputsNext;
    end
  end

  // An update on the final count edge beats the trip. While tripped the
  // count is frozen and updates are ignored unless a clear arrives with them.
  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_outputsNext = r_outputs;
    case (r_state)
      RUN: begin
        if (outputUpdate) begin
          w_outputsNext = w_shadowNext;
          w_countNext   = '0;
        end else if (r_count == c_CNT_LAST) begin
          w_stateNext   = TRIPPED;
          w_outputsNext = '0;
        end else begin
          w_countNext   = r_count + c_CNT_W'(1);
        end
      end
      TRIPPED: begin
        if (wdtClear) begin
          w_stateNext = RUN;
          w_countNext = '0;
          if (outputUpdate) begin
            w_outputsNext = w_shadowNext;
          end
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  assign wdtTrip = (r_state == TRIPPED);
`else
  logic w_unusedClear;
  assign w_unusedClear = wdtClear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outputs <= '0;
    end else if (outputUpdate) begin
      r_outputs <= w_shadowNext;
    end
  end

  assign wdtTrip = 1'b0;
`endif

  assign outputs       = r_outputs;
  assign outputReadOut = r_readOut;
  assign addrErr       = r_addrErr;

endmodule
`default_nettype wire
